// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types used by the memory-hierarchy blocks.
package lc3b_types;

    // Byte address and data word of the LC-3b core.
    typedef logic [15:0] lc3b_word;

    // One cache line as moved between the caches and physical memory.
    typedef logic [127:0] lc3b_block;

    // Arbiter FSM: idle, or serving exactly one cache's miss.
    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_SERVE_I = 2'd1,
        ARB_SERVE_D = 2'd2
    } arb_state_t;

endpackage : lc3b_types

// File: rtl/cache_arbiter.sv
// Shares the single physical-memory port between the I-cache and D-cache
// miss paths. One requester is granted at a time; its address, write data
// and operation are latched at the grant edge and drive pmem until
// pmem_resp, which is returned to that requester as a same-cycle pulse.
// When both caches wait, grants alternate so neither side can starve.
module cache_arbiter
    import lc3b_types::*;
#(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              rst,

    // I-cache miss path
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,

    // D-cache miss path
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,

    // Physical memory port
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    arb_state_t        r_state;
    arb_state_t        w_next_state;

    // Fairness bit: 1 when the most recent grant went to the D side.
    logic              r_last_d;
    // Latched D operation: 1 = writeback, 0 = line fill.
    logic              r_op_write;
    logic [ADDR_W-1:0] r_address;
    logic [LINE_W-1:0] r_wdata;

    logic              w_d_req;
    logic              w_grant_i;
    logic              w_grant_d;

    // A D request is either a fill or a writeback; both high counts as one.
    assign w_d_req = d_read | d_write;

    // Read data is steered to both caches; each only looks at it on its resp.
    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

    // The memory sees only the latched copies, never the live request inputs.
    assign pmem_address = r_address;
    assign pmem_wdata   = r_wdata;

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state, grant selection and strobe/response decode.
    always_comb begin
        w_next_state = r_state;
        w_grant_i    = 1'b0;
        w_grant_d    = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        i_resp       = 1'b0;
        d_resp       = 1'b0;

        case (r_state)
            ARB_IDLE: begin
                // pmem_resp is ignored here: nothing is outstanding.
                if (i_read && w_d_req) begin
                    // Contention: hand the port to whoever did not have it last.
                    if (r_last_d) begin
                        w_grant_i = 1'b1;
                    end else begin
                        w_grant_d = 1'b1;
                    end
                end else if (i_read) begin
                    w_grant_i = 1'b1;
                end else if (w_d_req) begin
                    w_grant_d = 1'b1;
                end

                if (w_grant_i) begin
                    w_next_state = ARB_SERVE_I;
                end else if (w_grant_d) begin
                    w_next_state = ARB_SERVE_D;
                end
            end

            ARB_SERVE_I: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    i_resp       = 1'b1;
                    w_next_state = ARB_IDLE;
                end
            end

            ARB_SERVE_D: begin
                pmem_read  = ~r_op_write;
                pmem_write = r_op_write;
                if (pmem_resp) begin
                    d_resp       = 1'b1;
                    w_next_state = ARB_IDLE;
                end
            end

            default: begin
                w_next_state = ARB_IDLE;
            end
        endcase
    end

    // Capture the winner's address, data and op, and record who won.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_d   <= 1'b0;
            r_op_write <= 1'b0;
            r_address  <= '0;
            r_wdata    <= '0;
        end else if (w_grant_i) begin
            r_last_d   <= 1'b0;
            r_address  <= i_address;
        end else if (w_grant_d) begin
            r_last_d   <= 1'b1;
            r_address  <= d_address;
            r_wdata    <= d_wdata;
            // A simultaneous read+write request is resolved as a writeback.
            r_op_write <= d_write;
        end
    end

endmodule : cache_arbiter

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: drives both cache miss paths and plays
// the memory side by hand, checking strobes, latched values and responses.
module tb_cache_arbiter;

    localparam int ADDR_W = 16;
    localparam int LINE_W = 128;

    logic              clk;
    logic              rst;
    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_address;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    int n_checks;
    int n_fail;
    int n_i_resp;
    int n_d_resp;

    localparam logic [LINE_W-1:0] LINE_A = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [LINE_W-1:0] LINE_B = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [LINE_W-1:0] LINE_C = 128'hA5A5_5A5A_C3C3_3C3C_0F0F_F0F0_9999_6666;
    localparam logic [LINE_W-1:0] LINE_W1 = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
    localparam logic [LINE_W-1:0] LINE_W2 = 128'hCAFE_F00D_0000_0000_0000_0000_1234_5678;

    cache_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_read       (i_read),
        .i_address    (i_address),
        .i_rdata      (i_rdata),
        .i_resp       (i_resp),
        .d_read       (d_read),
        .d_write      (d_write),
        .d_address    (d_address),
        .d_wdata      (d_wdata),
        .d_rdata      (d_rdata),
        .d_resp       (d_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count response pulses as seen by the caches at each clock edge.
    always @(posedge clk) begin
        if (i_resp) n_i_resp <= n_i_resp + 1;
        if (d_resp) n_d_resp <= n_d_resp + 1;
        if (d_read && d_write)
            $display("NOTE: protocol violation, d_read and d_write both high at %0t", $time);
    end

    task automatic chk(input string tag, input logic [LINE_W-1:0] got,
                       input logic [LINE_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    int base_i;
    int base_d;

    initial begin
        n_checks = 0; n_fail = 0; n_i_resp = 0; n_d_resp = 0;
        rst = 1'b1; i_read = 0; i_address = '0; d_read = 0; d_write = 0;
        d_address = '0; d_wdata = '0; pmem_rdata = '0; pmem_resp = 0;
        apply_reset();

        // Reset state
        chk("rst_pmem_read",  pmem_read,    1'b0);
        chk("rst_pmem_write", pmem_write,   1'b0);
        chk("rst_pmem_addr",  pmem_address, 16'h0000);
        chk("rst_pmem_wdata", pmem_wdata,   '0);
        chk("rst_i_resp",     i_resp,       1'b0);
        chk("rst_d_resp",     d_resp,       1'b0);
        tick();
        chk("idle_no_strobe", pmem_read | pmem_write, 1'b0);

        // I-only read x1A40, memory answers on the third cycle of service
        base_i = n_i_resp; base_d = n_d_resp;
        i_read = 1; i_address = 16'h1A40;
        tick();
        chk("t1_read_c1",  pmem_read,    1'b1);
        chk("t1_addr_c1",  pmem_address, 16'h1A40);
        chk("t1_write_c1", pmem_write,   1'b0);
        tick();
        chk("t1_read_c2",  pmem_read,    1'b1);
        chk("t1_iresp_c2", i_resp,       1'b0);
        tick();
        pmem_resp = 1; pmem_rdata = LINE_A;
        #1;
        chk("t1_iresp",  i_resp,  1'b1);
        chk("t1_irdata", i_rdata, LINE_A);
        chk("t1_dresp",  d_resp,  1'b0);
        tick();
        pmem_resp = 0; i_read = 0;
        chk("t1_read_off", pmem_read, 1'b0);
        tick();
        chk("t1_i_pulses", n_i_resp - base_i, 1);
        chk("t1_d_pulses", n_d_resp - base_d, 0);

        // Simultaneous I and D from reset: D first, then I after one idle cycle
        apply_reset();
        i_read = 1; i_address = 16'h0200;
        d_read = 1; d_address = 16'h3000;
        tick();
        chk("t2_first_addr", pmem_address, 16'h3000);
        chk("t2_first_read", pmem_read,    1'b1);
        pmem_resp = 1; pmem_rdata = LINE_B;
        #1;
        chk("t2_dresp",  d_resp,  1'b1);
        chk("t2_drdata", d_rdata, LINE_B);
        chk("t2_iresp0", i_resp,  1'b0);
        tick();
        pmem_resp = 0; d_read = 0;
        chk("t2_idle_gap", pmem_read, 1'b0);
        tick();
        chk("t2_second_addr", pmem_address, 16'h0200);
        chk("t2_second_read", pmem_read,    1'b1);
        pmem_resp = 1; pmem_rdata = LINE_C;
        #1;
        chk("t2_iresp",  i_resp,  1'b1);
        chk("t2_irdata", i_rdata, LINE_C);
        tick();
        pmem_resp = 0; i_read = 0;
        tick();

        // D writeback x4010
        d_write = 1; d_address = 16'h4010; d_wdata = LINE_W1;
        tick();
        chk("t3_write", pmem_write,   1'b1);
        chk("t3_read",  pmem_read,    1'b0);
        chk("t3_addr",  pmem_address, 16'h4010);
        chk("t3_wdata", pmem_wdata,   LINE_W1);
        tick();
        chk("t3_read_c2",  pmem_read,  1'b0);
        chk("t3_write_c2", pmem_write, 1'b1);
        pmem_resp = 1;
        #1;
        chk("t3_dresp", d_resp, 1'b1);
        tick();
        pmem_resp = 0; d_write = 0;
        chk("t3_write_off", pmem_write, 1'b0);
        tick();

        // D write then continuous D read with I waiting: order D, I, D
        apply_reset();
        i_read = 1; i_address = 16'h0100;
        d_write = 1; d_address = 16'h7000; d_wdata = LINE_W2;
        tick();
        chk("t4_g1_addr",  pmem_address, 16'h7000);
        chk("t4_g1_write", pmem_write,   1'b1);
        pmem_resp = 1;
        #1;
        chk("t4_g1_dresp", d_resp, 1'b1);
        tick();
        pmem_resp = 0; d_write = 0; d_read = 1; d_address = 16'h7100;
        tick();
        chk("t4_g2_addr", pmem_address, 16'h0100);
        chk("t4_g2_read", pmem_read,    1'b1);
        chk("t4_g2_nowr", pmem_write,   1'b0);
        pmem_resp = 1; pmem_rdata = LINE_A;
        #1;
        chk("t4_g2_iresp", i_resp, 1'b1);
        chk("t4_g2_dres0", d_resp, 1'b0);
        tick();
        pmem_resp = 0; i_read = 0;
        tick();
        chk("t4_g3_addr", pmem_address, 16'h7100);
        chk("t4_g3_read", pmem_read,    1'b1);
        pmem_resp = 1; pmem_rdata = LINE_B;
        #1;
        chk("t4_g3_dresp",  d_resp,  1'b1);
        chk("t4_g3_drdata", d_rdata, LINE_B);
        tick();
        pmem_resp = 0; d_read = 0;
        tick();

        // Reset during SERVE_D, late pmem_resp ignored, then fresh I request
        base_i = n_i_resp; base_d = n_d_resp;
        d_read = 1; d_address = 16'h5555;
        tick();
        chk("t5_serving", pmem_read, 1'b1);
        rst = 1;
        tick();
        rst = 0; d_read = 0;
        chk("t5_read_drop",  pmem_read,    1'b0);
        chk("t5_write_drop", pmem_write,   1'b0);
        chk("t5_addr_clr",   pmem_address, 16'h0000);
        pmem_resp = 1;
        #1;
        chk("t5_late_dresp", d_resp, 1'b0);
        chk("t5_late_iresp", i_resp, 1'b0);
        tick();
        pmem_resp = 0;
        chk("t5_still_idle", pmem_read | pmem_write, 1'b0);
        chk("t5_no_dpulse", n_d_resp - base_d, 0);
        i_read = 1; i_address = 16'h0A00;
        tick();
        chk("t5_i_addr", pmem_address, 16'h0A00);
        chk("t5_i_read", pmem_read,    1'b1);
        pmem_resp = 1; pmem_rdata = LINE_C;
        #1;
        chk("t5_i_resp", i_resp, 1'b1);
        tick();
        pmem_resp = 0; i_read = 0;
        tick();

        // d_address changes mid-transaction: pmem_address keeps the latched value
        d_read = 1; d_address = 16'h5000;
        tick();
        chk("t6_addr_c1", pmem_address, 16'h5000);
        d_address = 16'h6000;
        tick();
        chk("t6_addr_c2", pmem_address, 16'h5000);
        tick();
        chk("t6_addr_c3", pmem_address, 16'h5000);
        pmem_resp = 1; pmem_rdata = LINE_A;
        #1;
        chk("t6_dresp",     d_resp,       1'b1);
        chk("t6_addr_resp", pmem_address, 16'h5000);
        tick();
        pmem_resp = 0; d_read = 0;
        tick();

        // d_read and d_write together are served as a writeback
        d_read = 1; d_write = 1; d_address = 16'h2220; d_wdata = LINE_B;
        tick();
        chk("t7_write", pmem_write, 1'b1);
        chk("t7_read",  pmem_read,  1'b0);
        chk("t7_wdata", pmem_wdata, LINE_B);
        pmem_resp = 1;
        #1;
        chk("t7_dresp", d_resp, 1'b1);
        tick();
        pmem_resp = 0; d_read = 0; d_write = 0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_cache_arbiter
